// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice: FSM state encoding,
// default address window base, bus widths and the delay-LFSR seed.
package mem_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 8;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE = 32'h8000_0000;
  localparam logic [7:0]        LFSR_SEED    = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps once per enable pulse and
// returns to SEED on synchronous reset.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic feedback;

  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], feedback};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits a fixed (or
// pseudo-randomly stretched) latency, then holds a response until taken.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE        = DEFAULT_BASE,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2,
  parameter bit                RAND_DELAY  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output state_t            dbg_state
);

  // Handshake: a transfer happens on the rising edge where valid && ready are
  // both high; the responder holds resp_* stable until that edge.

  localparam int                IDX_W = $clog2(DEPTH_WORDS);
  localparam int                CNT_W = 5;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH_WORDS);

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n, load_cnt;
  logic                wen_q, ok_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          mask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                accept, enter_resp;
  logic [ADDR_W-1:0]   offset;
  logic                req_ok;
  logic [IDX_W-1:0]    req_idx;
  logic [7:0]          lfsr_val;
  logic [1:0]          extra;
  logic                act_wen, act_ok;
  logic [IDX_W-1:0]    act_idx;
  logic [DATA_W-1:0]   act_wdata;
  logic [3:0]          act_mask;
  logic [DATA_W-1:0]   mem [DEPTH_WORDS];
  logic                unused_bits;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

  // Full-width offset so addresses below BASE wrap to huge values and fail.
  assign offset  = {req_addr[ADDR_W-1:2], 2'b00} - BASE;
  assign req_ok  = (offset < SPAN);
  assign req_idx = offset[IDX_W+1:2];

  generate
    if (RAND_DELAY) begin : g_lfsr
      lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .q   (lfsr_val)
      );
      assign extra = lfsr_val[1:0];
    end else begin : g_no_lfsr
      assign lfsr_val = LFSR_SEED;
      assign extra    = 2'd0;
    end
  endgenerate

  assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  assign unused_bits = ^{req_wmask[MASK_W-1:4], req_addr[1:0], lfsr_val[7:2],
                         offset[ADDR_W-1:IDX_W+2], offset[1:0]};

  // Zero-wait requests enter RESP straight from IDLE, so the memory action
  // must use the live request rather than the not-yet-latched copy.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    enter_resp = 1'b0;
    act_wen    = wen_q;
    act_ok     = ok_q;
    act_idx    = idx_q;
    act_wdata  = wdata_q;
    act_mask   = mask_q;
    case (state_q)
      IDLE: begin
        act_wen   = req_wen;
        act_ok    = req_ok;
        act_idx   = req_idx;
        act_wdata = req_wdata;
        act_mask  = req_wmask[3:0];
        if (accept) begin
          cnt_n = load_cnt;
          if (load_cnt == '0) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt_q - 1'b1;
        if (cnt_n == '0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      ok_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (accept) begin
        wen_q   <= req_wen;
        ok_q    <= req_ok;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        mask_q  <= req_wmask[3:0];
      end
      if (enter_resp) begin
        err_q   <= !act_ok;
        rdata_q <= (act_ok && !act_wen) ? mem[act_idx] : '0;
      end
    end
  end

  // Storage has no reset; a reset during WAIT suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && act_ok && act_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (act_mask[b]) mem[act_idx][8*b +: 8] <= act_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a fixed-latency instance for the directed
// vectors and a RAND_DELAY instance checked against a small reference memory.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_wen, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [7:0]  a_req_wmask;
  state_t      a_state;

  logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [7:0]  b_req_wmask;
  state_t      b_state;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [8];

  mem_responder u_dut (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .dbg_state(a_state)
  );

  mem_responder #(.LATENCY(1), .RAND_DELAY(1'b1)) u_rnd (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .dbg_state(b_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic f_ready(input int sel);
    return (sel == 0) ? a_req_ready : b_req_ready;
  endfunction
  function automatic logic f_valid(input int sel);
    return (sel == 0) ? a_resp_valid : b_resp_valid;
  endfunction
  function automatic logic f_err(input int sel);
    return (sel == 0) ? a_resp_err : b_resp_err;
  endfunction
  function automatic logic [31:0] f_rdata(input int sel);
    return (sel == 0) ? a_resp_rdata : b_resp_rdata;
  endfunction

  task automatic drive(input int sel, input logic v, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] mask);
    if (sel == 0) begin
      a_req_valid = v; a_req_wen = wen; a_req_addr = addr; a_req_wdata = wdata; a_req_wmask = mask;
    end else begin
      b_req_valid = v; b_req_wen = wen; b_req_addr = addr; b_req_wdata = wdata; b_req_wmask = mask;
    end
  endtask

  task automatic set_rr(input int sel, input logic r);
    if (sel == 0) a_resp_ready = r;
    else          b_resp_ready = r;
  endtask

  // One full request/response; resp_ready is held low for `hold` cycles after
  // resp_valid is first seen, with stability checks in each held cycle.
  task automatic txn(input int sel, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [7:0] mask, input int hold,
                     output logic [31:0] rdata, output logic err, output int lat);
    int t;
    @(negedge clk);
    set_rr(sel, 1'b0);
    drive(sel, 1'b1, wen, addr, wdata, mask);
    t = 0;
    while (!f_ready(sel) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("req_ready_wait_bound", 32'(t >= 50), 32'd0);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!f_valid(sel) && lat < 40);
    check_val("resp_valid_wait_bound", 32'(f_valid(sel)), 32'd1);
    rdata = f_rdata(sel);
    err   = f_err(sel);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(f_valid(sel)), 32'd1);
      check_val("hold_rdata", f_rdata(sel), rdata);
      check_val("hold_err", 32'(f_err(sel)), 32'(err));
      check_val("hold_req_ready", 32'(f_ready(sel)), 32'd0);
    end
    set_rr(sel, 1'b1);
    @(negedge clk);
    check_val("resp_done", 32'(f_valid(sel)), 32'd0);
    set_rr(sel, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        wen;
    int          w;
    logic [31:0] d;
    logic [3:0]  m;

    // Reset with a request presented on the fixed-latency instance; it must be ignored.
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h0F);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0);
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);
    repeat (3) @(negedge clk);
    check_val("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check_val("rst_rdata", a_resp_rdata, 32'd0);
    check_val("rst_err", 32'(a_resp_err), 32'd0);
    check_val("rst_state", 32'(a_state), 32'(IDLE));
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0);
    @(negedge clk);
    check_val("rst_accept_ignored", 32'(a_state), 32'(IDLE));
    check_val("rst_req_ready", 32'(a_req_ready), 32'd1);

    // Basic write then read with LATENCY=2.
    txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, rd, er, lat);
    check_val("wr_lat", lat, 32'd2);
    check_val("wr_rdata", rd, 32'd0);
    check_val("wr_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h8000_0010, 32'd0, 8'd0, 0, rd, er, lat);
    check_val("rd_lat", lat, 32'd2);
    check_val("rd_rdata", rd, 32'hDEAD_BEEF);
    check_val("rd_err", 32'(er), 32'd0);

    // Byte-lane masking, then a zero-lane write (upper mask bits must not count).
    txn(0, 1'b1, 32'h8000_0014, 32'h1122_3344, 8'h0F, 0, rd, er, lat);
    txn(0, 1'b1, 32'h8000_0014, 32'hAABB_CCDD, 8'h05, 0, rd, er, lat);
    txn(0, 1'b0, 32'h8000_0014, 32'd0, 8'd0, 0, rd, er, lat);
    check_val("mask_rdata", rd, 32'h11BB_33DD);
    txn(0, 1'b1, 32'h8000_0014, 32'hFFFF_FFFF, 8'hF0, 0, rd, er, lat);
    check_val("mask0_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h8000_0014, 32'd0, 8'd0, 0, rd, er, lat);
    check_val("mask0_rdata", rd, 32'h11BB_33DD);

    // Backpressure: five held cycles, completion on the first resp_ready.
    txn(0, 1'b0, 32'h8000_0010, 32'd0, 8'd0, 5, rd, er, lat);
    check_val("bp_rdata", rd, 32'hDEAD_BEEF);

    // Out-of-range accesses on both sides of the window.
    txn(0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 8'h0F, 0, rd, er, lat);
    txn(0, 1'b0, 32'h7FFF_FFFC, 32'd0, 8'd0, 0, rd, er, lat);
    check_val("err_below_err", 32'(er), 32'd1);
    check_val("err_below_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h8000_1000, 32'd0, 8'd0, 0, rd, er, lat);
    check_val("err_above_err", 32'(er), 32'd1);
    check_val("err_above_rdata", rd, 32'd0);
    txn(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, 0, rd, er, lat);
    check_val("err_wr_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h8000_0000, 32'd0, 8'd0, 0, rd, er, lat);
    check_val("word0_kept", rd, 32'h0BAD_F00D);
    check_val("word0_err", 32'(er), 32'd0);

    // Last in-range word, and address bits [1:0] ignored.
    txn(0, 1'b1, 32'h8000_0FFC, 32'h5A5A_A5A5, 8'h0F, 0, rd, er, lat);
    check_val("top_wr_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h8000_0FFF, 32'd0, 8'd0, 0, rd, er, lat);
    check_val("top_rdata", rd, 32'h5A5A_A5A5);
    check_val("top_err", 32'(er), 32'd0);

    // Reset during WAIT of a write must drop the write.
    txn(0, 1'b1, 32'h8000_0020, 32'h1234_5678, 8'h0F, 0, rd, er, lat);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 8'h0F);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0);
    @(negedge clk);
    check_val("mid_wait_state", 32'(a_state), 32'(WAIT));
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_valid", 32'(a_resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", 32'(a_req_ready), 32'd1);
    txn(0, 1'b0, 32'h8000_0020, 32'd0, 8'd0, 0, rd, er, lat);
    check_val("post_rst_rdata", rd, 32'h1234_5678);

    // Random-delay instance: seed a reference memory, then random traffic.
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      ref_mem[i] = d;
      txn(1, 1'b1, 32'h8000_0000 + 32'(4 * i), d, 8'h0F, 0, rd, er, lat);
      check_val("rnd_init_lat", 32'(lat >= 1 && lat <= 4), 32'd1);
    end
    for (int n = 0; n < 100; n++) begin
      wen = 1'($urandom_range(0, 1));
      w   = $urandom_range(0, 7);
      d   = $urandom;
      m   = 4'($urandom_range(0, 15));
      if (!wen) exp_q.push_back(ref_mem[w]);
      txn(1, wen, 32'h8000_0000 + 32'(4 * w), d, {4'h0, m}, $urandom_range(0, 3), rd, er, lat);
      check_val("rnd_lat", 32'(lat >= 1 && lat <= 4), 32'd1);
      check_val("rnd_err", 32'(er), 32'd0);
      if (wen) begin
        for (int b = 0; b < 4; b++) if (m[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        check_val("rnd_wr_rdata", rd, 32'd0);
      end else begin
        check_val("rnd_rd_rdata", rd, exp_q.pop_front());
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
